rr_arbiter16: RTL and testbench

- Round-robin arbiter that shares one 16-way decoded resource (e.g. a peripheral select bus) between 16 requesters.
- Holds a 4-bit owner index, decodes it to a one-hot grant, and keeps ownership until the owner signals completion, drops its request, or exceeds a hold limit.
- Sits between requesting masters and the decoder-driven select lines of the shared resource.

---
 rtl/arb_pkg.sv | 12 +
 rtl/dec4to16.sv | 15 +
 rtl/rr_arbiter16.sv | 102 ++++++++++
 tb/tb_rr_arbiter16.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: FSM encoding and sizes.
package arb_pkg;

  localparam int NREQ  = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/dec4to16.sv
// 4-to-16 one-hot decoder with an enable; all outputs low when en is low.
module dec4to16 (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] dec
);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dec
      assign dec[gi] = en && (idx == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for one shared 16-way resource. Ownership is held until done,
// request drop, or the hold limit; grant is decoded purely from registered state.
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   grant_id_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   hold_cnt_reg;
  logic               busy_reg;
  logic               timeout_reg;

  logic [IDX_W-1:0]   pick_next;
  logic               owner_quit;
  logic               limit_hit;

  // First requester at or after the pointer, scanning upward with 4-bit wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             found;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = p + IDX_W'(k);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick_next  = rr_pick(req, ptr_reg);
  assign owner_quit = done || !req[grant_id_reg];
  assign limit_hit  = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      grant_id_reg <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req != '0) begin
            grant_id_reg <= pick_next;
            hold_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (owner_quit || limit_hit) begin
            // A voluntary release wins over the hold limit when both occur together.
            timeout_reg <= limit_hit && !owner_quit;
            ptr_reg     <= grant_id_reg + 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (hold_cnt_reg != '1) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  dec4to16 u_dec (
    .idx (grant_id_reg),
    .en  (busy_reg),
    .dec (grant)
  );

  assign grant_id = grant_id_reg;
  assign busy     = busy_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic, all
// compared cycle by cycle against an integer-level model of the arbitration rules.
module tb_rr_arbiter16;

  localparam int MAXH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        busy;
  logic        timeout;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: owner index, busy flag, rotation start, cycles held.
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_busy  = 0;
  bit m_to    = 0;
  bit m_new   = 0;

  rr_arbiter16 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_update(input logic [15:0] r, input bit d, input bit rs);
    bit quit;
    bit lim;
    int idx;
    m_new = 0;
    if (rs) begin
      m_owner = 0; m_ptr = 0; m_cnt = 0; m_busy = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (r != 16'h0000) begin
        for (int k = 0; k < 16; k++) begin
          idx = (m_ptr + k) % 16;
          if (r[idx]) begin
            m_owner = idx;
            break;
          end
        end
        m_busy = 1; m_cnt = 0; m_new = 1;
      end
    end else begin
      quit = d || !r[m_owner];
      lim  = (MAXH != 0) && (m_cnt == MAXH - 1);
      if (quit || lim) begin
        m_to   = lim && !quit;
        m_ptr  = (m_owner + 1) % 16;
        m_busy = 0;
      end else begin
        m_to  = 0;
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step(input logic [15:0] r, input bit d, input bit rs);
    logic [15:0] exp_grant;
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_update(r, d, rs);
    #1;
    cyc++;
    exp_grant = m_busy ? (16'h0001 << m_owner) : 16'h0000;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("timeout", 32'(timeout), 32'(m_to));
    $display("cyc %0d rst=%0b req=%h done=%0b -> grant=%h id=%0d busy=%0b to=%0b",
             cyc, rs, r, d, grant, grant_id, busy, timeout);
  endtask

  initial begin
    int seq_n;
    int hold;
    bit seen_to;
    logic [15:0] r;
    req = 16'h0000; done = 1'b0; rst = 1'b1;

    // Reset with everyone requesting, then first grant goes to requester 0.
    for (int i = 0; i < 3; i++) step(16'hFFFF, 0, 1);
    step(16'hFFFF, 0, 0);
    chk("first_grant", 32'(grant), 32'h0001);

    // Full rotation with done on every third busy cycle.
    seq_n = 1;
    for (int i = 0; i < 200 && seq_n < 17; i++) begin
      step(16'hFFFF, (m_busy && m_cnt == 2), 0);
      if (m_new) begin
        chk("rr_order", 32'(grant_id), 32'(seq_n % 16));
        seq_n++;
      end
    end
    chk("rr_complete", 32'(seq_n), 32'd17);

    // Skip and wrap.
    step(16'h8001, 1, 0);
    step(16'h8001, 0, 0);
    chk("skip_to_15", 32'(grant_id), 32'd15);
    step(16'h8001, 1, 0);
    step(16'h8001, 0, 0);
    chk("wrap_to_0", 32'(grant_id), 32'd0);
    step(16'h0024, 1, 0);
    step(16'h0024, 0, 0);
    chk("ptr1_pick2", 32'(grant_id), 32'd2);
    step(16'h0024, 1, 0);
    step(16'h0024, 0, 0);
    chk("ptr3_pick5", 32'(grant_id), 32'd5);

    // Hold-limit timeout on a lone requester.
    step(16'h0024, 1, 0);
    step(16'h0010, 0, 0);
    hold = (grant == 16'h0010) ? 1 : 0;
    seen_to = 0;
    for (int i = 0; i < 10 && !seen_to; i++) begin
      step(16'h0010, 0, 0);
      if (grant == 16'h0010) hold++;
      if (timeout) seen_to = 1;
    end
    chk("to_seen", 32'(seen_to), 32'd1);
    chk("to_hold_cycles", 32'(hold), 32'(MAXH));
    chk("to_grant_low", 32'(grant), 32'h0000);
    step(16'h0010, 0, 0);
    chk("to_regrant", 32'(grant), 32'h0010);

    // done coinciding with the hold limit: voluntary release, no timeout.
    for (int i = 0; i < 10 && m_cnt != MAXH - 1; i++) step(16'h0010, 0, 0);
    step(16'h0010, 1, 0);
    chk("done_at_limit_to", 32'(timeout), 32'd0);
    chk("done_at_limit_busy", 32'(busy), 32'd0);

    // Owner drops its request mid-grant.
    step(16'h0010, 0, 0);
    step(16'h0010, 0, 0);
    step(16'h0020, 0, 0);
    chk("drop_release", 32'(busy), 32'd0);

    // done while idle changes nothing; grant_id keeps last owner.
    step(16'h0000, 1, 0);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_keep_id", 32'(grant_id), 32'd4);

    // Reset while owner 7 holds the grant.
    step(16'h0080, 0, 0);
    chk("own7", 32'(grant_id), 32'd7);
    step(16'h0080, 0, 0);
    step(16'h0080, 0, 1);
    chk("mid_rst_grant", 32'(grant), 32'h0000);
    chk("mid_rst_id", 32'(grant_id), 32'd0);
    step(16'h0081, 0, 0);
    chk("post_rst_pick0", 32'(grant_id), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'($urandom);
        1:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       r = 16'h0001 << $urandom_range(0, 15);
        default: r = (m_busy && $urandom_range(0, 3) != 0) ?
                     (16'($urandom) | (16'h0001 << m_owner)) : 16'($urandom);
      endcase
      step(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
